// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 16-bit core: a Moore FSM drives the shared ALU and memory-port
// controls, and mem_ready / ALU flags qualify the PC/IR enables, store completion and branches.
module multicycle_control #(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                alu_zero,
    input  logic                alu_lt,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_source,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                instr_done,
    output logic                illegal_op,
    output logic                mem_timeout
);

    localparam int CNT_W = 8;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(4'b0000);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(4'b0001);
    localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(4'b0010);
    localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(4'b0011);
    localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(4'b0100);
    localparam logic [OPCODE_W-1:0] OP_LHW  = OPCODE_W'(4'b0111);
    localparam logic [OPCODE_W-1:0] OP_SHW  = OPCODE_W'(4'b1000);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(4'b1001);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(4'b1010);
    localparam logic [OPCODE_W-1:0] OP_BLT  = OPCODE_W'(4'b1011);
    localparam logic [OPCODE_W-1:0] OP_BGT  = OPCODE_W'(4'b1100);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(4'b1111);

    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b100);
    localparam logic [ALUOP_W-1:0] ALU_CMP   = ALUOP_W'(3'b101);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        BRANCH,
        JUMP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_count;
    logic [CNT_W-1:0] count_next;
    logic             waiting;
    logic             timed_out;
    logic             branch_taken;

    function automatic state_t decode_target(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_R:                               return EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SUBI:  return EXEC_I;
            OP_LHW, OP_SHW:                     return MEM_ADDR;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGT:     return BRANCH;
            OP_J:                               return JUMP;
            default:                            return FETCH;
        endcase
    endfunction

    // Only the three memory-wait states can stall; all others advance unconditionally.
    assign waiting   = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign timed_out = waiting && !mem_ready && (wait_count == CNT_W'(TIMEOUT));

    always_comb begin
        branch_taken = 1'b0;
        case (opcode)
            OP_BEQ:  branch_taken = alu_zero;
            OP_BNE:  branch_taken = !alu_zero;
            OP_BLT:  branch_taken = alu_lt;
            OP_BGT:  branch_taken = !alu_lt && !alu_zero;
            default: branch_taken = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state      <= FETCH;
            wait_count <= '0;
        end else begin
            state      <= state_next;
            wait_count <= count_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:    state_next = mem_ready ? DECODE : FETCH;
            DECODE:   state_next = decode_target(opcode);
            EXEC_R:   state_next = ALU_WB;
            EXEC_I:   state_next = ALU_WB;
            ALU_WB:   state_next = FETCH;
            MEM_ADDR: begin
                if (opcode == OP_LHW)      state_next = MEM_RD;
                else if (opcode == OP_SHW) state_next = MEM_WR;
                else                       state_next = FETCH;
            end
            MEM_RD: begin
                if (mem_ready)      state_next = MEM_WB;
                else if (timed_out) state_next = FETCH;
            end
            MEM_WB:   state_next = FETCH;
            MEM_WR:   state_next = (mem_ready || timed_out) ? FETCH : MEM_WR;
            BRANCH:   state_next = FETCH;
            JUMP:     state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    // A FETCH timeout loops FETCH->FETCH, so the abort itself must also clear the counter.
    always_comb begin
        count_next = '0;
        if (!timed_out && state_next == state && waiting && !mem_ready)
            count_next = wait_count + CNT_W'(1);
    end

    // Output logic; reset forces the idle pattern so an aborted instruction leaves no strobe.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_source   = 2'b00;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = ALU_ADD;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        if (!reset) begin
            mem_timeout = timed_out;
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b = 2'b10;
                    if (decode_target(opcode) == FETCH) begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_ANDI: alu_op = ALU_AND;
                        OP_ORI:  alu_op = ALU_OR;
                        OP_SUBI: alu_op = ALU_SUB;
                        default: alu_op = ALU_ADD;
                    endcase
                end
                ALU_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (opcode == OP_R);
                    instr_done = 1'b1;
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                MEM_WR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_CMP;
                    pc_source  = 2'b01;
                    pc_write   = branch_taken;
                    instr_done = 1'b1;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a vector table of per-cycle inputs and expected
// control words, followed by hand-written latency sequences.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       alu_zero;
    logic       alu_lt;
    logic       ir_write, pc_write, i_or_d, mem_read, mem_write, mem_to_reg;
    logic       reg_write, reg_dst, alu_src_a, instr_done, illegal_op, mem_timeout;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_op;

    multicycle_control #(.OPCODE_W(4), .ALUOP_W(3), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .alu_zero   (alu_zero),
        .alu_lt     (alu_lt),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
        logic       mem_timeout;
    } outs_t;

    typedef struct {
        string      name;
        bit         rst;
        logic [3:0] op;
        bit         rdy;
        bit         zero;
        bit         lt;
        outs_t      exp;
    } vec_t;

    outs_t act;
    assign act = {ir_write, pc_write, pc_source, i_or_d, mem_read, mem_write, mem_to_reg,
                  reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, instr_done, illegal_op,
                  mem_timeout};

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, got, want);
    endtask

    // Expected control words per state, written out by hand.
    function automatic outs_t o_idle();
        outs_t o = '0;
        o.alu_op = 3'b001;
        return o;
    endfunction
    function automatic outs_t o_fetch(input bit rdy);
        outs_t o = o_idle();
        o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction
    function automatic outs_t o_fetch_to();
        outs_t o = o_fetch(1'b0);
        o.mem_timeout = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_decode(input bit illegal);
        outs_t o = o_idle();
        o.alu_src_b = 2'b10; o.illegal_op = illegal; o.instr_done = illegal;
        return o;
    endfunction
    function automatic outs_t o_exec_r();
        outs_t o = o_idle();
        o.alu_src_a = 1'b1; o.alu_op = 3'b000;
        return o;
    endfunction
    function automatic outs_t o_exec_i(input logic [2:0] aop);
        outs_t o = o_idle();
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = aop;
        return o;
    endfunction
    function automatic outs_t o_alu_wb(input bit rd);
        outs_t o = o_idle();
        o.reg_write = 1'b1; o.reg_dst = rd; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_mem_addr();
        outs_t o = o_idle();
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        return o;
    endfunction
    function automatic outs_t o_mem_rd(input bit to);
        outs_t o = o_idle();
        o.mem_read = 1'b1; o.i_or_d = 1'b1; o.mem_timeout = to;
        return o;
    endfunction
    function automatic outs_t o_mem_wb();
        outs_t o = o_idle();
        o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_mem_wr(input bit rdy);
        outs_t o = o_idle();
        o.mem_write = 1'b1; o.i_or_d = 1'b1; o.instr_done = rdy;
        return o;
    endfunction
    function automatic outs_t o_branch(input bit taken);
        outs_t o = o_idle();
        o.alu_src_a = 1'b1; o.alu_op = 3'b101; o.pc_source = 2'b01;
        o.pc_write = taken; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_jump();
        outs_t o = o_idle();
        o.pc_write = 1'b1; o.pc_source = 2'b10; o.instr_done = 1'b1;
        return o;
    endfunction

    function automatic void add(input string name, input bit rst, input logic [3:0] op,
                                input bit rdy, input bit zero, input bit lt, input outs_t exp);
        vec_t v;
        v.name = name; v.rst = rst; v.op = op; v.rdy = rdy; v.zero = zero; v.lt = lt; v.exp = exp;
        vecs.push_back(v);
    endfunction

    // One three-cycle branch with flags held for the whole instruction.
    function automatic void add_branch(input string name, input logic [3:0] op,
                                       input bit zero, input bit lt, input bit taken);
        add({name, "_fetch"},  0, op, 1, zero, lt, o_fetch(1));
        add({name, "_decode"}, 0, op, 1, zero, lt, o_decode(0));
        add({name, "_branch"}, 0, op, 1, zero, lt, o_branch(taken));
    endfunction

    // Applies inputs, samples on the falling edge, then lets the rising edge advance the FSM.
    task automatic apply(input vec_t v);
        reset = v.rst; opcode = v.op; mem_ready = v.rdy; alu_zero = v.zero; alu_lt = v.lt;
        @(negedge clk);
        check(v.name, 32'(act), 32'(v.exp));
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from the first FETCH cycle through the instr_done cycle, bounded.
    task automatic measure(input string name, input logic [3:0] op, input int want);
        int cyc    = 0;
        int pulses = 0;
        reset = 1'b1; opcode = op; mem_ready = 1'b1; alu_zero = 1'b1; alu_lt = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        while (pulses == 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (instr_done) pulses++;
            @(posedge clk);
            #1;
        end
        check({name, "_latency"}, 32'(cyc), 32'(want));
        // The cycle after retirement must be a fresh FETCH with no second pulse.
        @(negedge clk);
        check({name, "_next_fetch"}, 32'(act), 32'(o_fetch(1)));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 4'b0000; mem_ready = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0;

        add("reset_0", 1, 4'b0000, 0, 0, 0, o_idle());
        add("reset_1", 1, 4'b0000, 0, 0, 0, o_idle());
        add("addi_fetch",  0, 4'b0001, 1, 0, 0, o_fetch(1));
        add("addi_decode", 0, 4'b0001, 1, 0, 0, o_decode(0));
        add("addi_exec",   0, 4'b0001, 1, 0, 0, o_exec_i(3'b001));
        add("addi_wb",     0, 4'b0001, 1, 0, 0, o_alu_wb(0));
        add("r_fetch",  0, 4'b0000, 1, 0, 0, o_fetch(1));
        add("r_decode", 0, 4'b0000, 1, 0, 0, o_decode(0));
        add("r_exec",   0, 4'b0000, 1, 0, 0, o_exec_r());
        add("r_wb",     0, 4'b0000, 1, 0, 0, o_alu_wb(1));
        add("ori_fetch",  0, 4'b0011, 1, 0, 0, o_fetch(1));
        add("ori_decode", 0, 4'b0011, 1, 0, 0, o_decode(0));
        add("ori_exec",   0, 4'b0011, 1, 0, 0, o_exec_i(3'b011));
        add("ori_wb",     0, 4'b0011, 1, 0, 0, o_alu_wb(0));
        add("subi_fetch",  0, 4'b0100, 1, 0, 0, o_fetch(1));
        add("subi_decode", 0, 4'b0100, 1, 0, 0, o_decode(0));
        add("subi_exec",   0, 4'b0100, 1, 0, 0, o_exec_i(3'b100));
        add("subi_wb",     0, 4'b0100, 1, 0, 0, o_alu_wb(0));

        add("lhw_fetch", 0, 4'b0111, 1, 0, 0, o_fetch(1));
        add("lhw_decode", 0, 4'b0111, 1, 0, 0, o_decode(0));
        add("lhw_addr", 0, 4'b0111, 1, 0, 0, o_mem_addr());
        for (int i = 0; i < 3; i++) add("lhw_rd_wait", 0, 4'b0111, 0, 0, 0, o_mem_rd(0));
        add("lhw_rd_done", 0, 4'b0111, 1, 0, 0, o_mem_rd(0));
        add("lhw_wb", 0, 4'b0111, 1, 0, 0, o_mem_wb());

        add("shw_fetch", 0, 4'b1000, 1, 0, 0, o_fetch(1));
        add("shw_decode", 0, 4'b1000, 1, 0, 0, o_decode(0));
        add("shw_addr", 0, 4'b1000, 1, 0, 0, o_mem_addr());
        add("shw_wr_wait", 0, 4'b1000, 0, 0, 0, o_mem_wr(0));
        add("shw_wr_done", 0, 4'b1000, 1, 0, 0, o_mem_wr(1));

        add_branch("beq_z1",    4'b1001, 1, 0, 1);
        add_branch("beq_z0",    4'b1001, 0, 1, 0);
        add_branch("bne_z1",    4'b1010, 1, 0, 0);
        add_branch("blt_lt1",   4'b1011, 0, 1, 1);
        add_branch("bgt_z1",    4'b1100, 1, 0, 0);
        add_branch("bgt_z0lt0", 4'b1100, 0, 0, 1);

        add("j_fetch", 0, 4'b1111, 1, 0, 0, o_fetch(1));
        add("j_decode", 0, 4'b1111, 1, 0, 0, o_decode(0));
        add("j_jump", 0, 4'b1111, 1, 0, 0, o_jump());
        add("ill_1101_fetch", 0, 4'b1101, 1, 0, 0, o_fetch(1));
        add("ill_1101_decode", 0, 4'b1101, 1, 0, 0, o_decode(1));
        add("ill_0101_fetch", 0, 4'b0101, 1, 0, 0, o_fetch(1));
        add("ill_0101_decode", 0, 4'b0101, 1, 0, 0, o_decode(1));

        // FETCH timeout: 15 waiting cycles, abort on the 16th, then a fresh count.
        for (int i = 0; i < 15; i++) add("fetch_wait", 0, 4'b0000, 0, 0, 0, o_fetch(0));
        add("fetch_timeout", 0, 4'b0000, 0, 0, 0, o_fetch_to());
        add("fetch_after_to", 0, 4'b0000, 0, 0, 0, o_fetch(0));

        // MEM_RD timeout returns to FETCH without write-back.
        add("lhw_to_fetch", 0, 4'b0111, 1, 0, 0, o_fetch(1));
        add("lhw_to_decode", 0, 4'b0111, 1, 0, 0, o_decode(0));
        add("lhw_to_addr", 0, 4'b0111, 1, 0, 0, o_mem_addr());
        for (int i = 0; i < 15; i++) add("lhw_to_wait", 0, 4'b0111, 0, 0, 0, o_mem_rd(0));
        add("lhw_timeout", 0, 4'b0111, 0, 0, 0, o_mem_rd(1));
        add("lhw_to_refetch", 0, 4'b1000, 1, 0, 0, o_fetch(1));

        // mem_ready on the timeout cycle of MEM_WR completes normally.
        add("shw_race_decode", 0, 4'b1000, 1, 0, 0, o_decode(0));
        add("shw_race_addr", 0, 4'b1000, 1, 0, 0, o_mem_addr());
        for (int i = 0; i < 15; i++) add("shw_race_wait", 0, 4'b1000, 0, 0, 0, o_mem_wr(0));
        add("shw_race_done", 0, 4'b1000, 1, 0, 0, o_mem_wr(1));

        // Reset in the middle of a store: no strobe during reset, FETCH afterwards.
        add("shw_rst_fetch", 0, 4'b1000, 1, 0, 0, o_fetch(1));
        add("shw_rst_decode", 0, 4'b1000, 1, 0, 0, o_decode(0));
        add("shw_rst_addr", 0, 4'b1000, 1, 0, 0, o_mem_addr());
        add("shw_rst_wr", 0, 4'b1000, 0, 0, 0, o_mem_wr(0));
        add("shw_rst_reset", 1, 4'b1000, 1, 0, 0, o_idle());
        add("shw_rst_after", 0, 4'b1000, 0, 0, 0, o_fetch(0));

        foreach (vecs[i]) apply(vecs[i]);

        measure("r_type", 4'b0000, 4);
        measure("i_type", 4'b0010, 4);
        measure("lhw",    4'b0111, 5);
        measure("shw",    4'b1000, 4);
        measure("branch", 4'b1010, 3);
        measure("jump",   4'b1111, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the 16-bit, 4-bit-opcode core ISA. It replaces the single-cycle decoder when the datapath shares one ALU and one memory port across cycles.
- Drives PC/IR enables, memory strobes, ALU operand selects and register-file write through a Moore FSM. A Mealy qualification on the memory ready signal and the ALU flags gates the PC/IR enables.
- Emits a one-cycle retire pulse per instruction and flags illegal opcodes and memory timeouts.

Parameters:
- OPCODE_W, 4, opcode field width.
- ALUOP_W, 3, ALU operation code width.
- TIMEOUT, 15, max cycles a memory state waits for mem_ready before aborting; range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  OPCODE_W  instruction-register opcode field; valid from DECODE onward.
- mem_ready  input  1  memory completes the current read/write this cycle.
- alu_zero  input  1  ALU result == 0.
- alu_lt  input  1  signed A < B.
- ir_write  output  1  load instruction register.
- pc_write  output  1  load PC.
- pc_source  output  2  00 ALU result, 01 branch target register, 10 jump target.
- i_or_d  output  1  memory address: 0 PC, 1 ALU-out register.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_to_reg  output  1  write-back data: 0 ALU-out, 1 memory-data register.
- reg_write  output  1  register-file write enable.
- reg_dst  output  1  destination: 0 rt, 1 rd.
- alu_src_a  output  1  A operand: 0 PC, 1 rs.
- alu_src_b  output  2  B operand: 00 rt, 01 constant 2, 10 sign-extended immediate.
- alu_op  output  ALUOP_W  000 funct, 001 add, 010 and, 011 or, 100 sub, 101 compare.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- illegal_op  output  1  one-cycle pulse on an undefined opcode.
- mem_timeout  output  1  one-cycle pulse on a memory timeout abort.

Behaviour:
- States: FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP.
- Reset: state=FETCH, wait counter=0, every output 0 except alu_op=001. Reset mid-instruction aborts it with no write or strobe in the reset cycle.
- Default: every output not listed for a state is 0, with alu_op=001.
- FETCH:
  - Drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=001.
  - ir_write=pc_write=mem_ready, pc_source=00.
  - Stay while !mem_ready; go to DECODE on mem_ready.
- DECODE:
  - Drive alu_src_a=0, alu_src_b=10, alu_op=001 (branch target precompute).
  - Next state by opcode:
    - 0000 -> EXEC_R.
    - 0001/0010/0011/0100 -> EXEC_I.
    - 0111/1000 -> MEM_ADDR.
    - 1001..1100 -> BRANCH.
    - 1111 -> JUMP.
    - Any other opcode -> FETCH with illegal_op=1 and instr_done=1 (treated as NOP).
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=000; then ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op from opcode (0001:001, 0010:010, 0011:011, 0100:100); then ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1 if opcode==0000 else 0, instr_done=1; then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=001; then MEM_RD for opcode 0111 (lhw), MEM_WR for 1000 (shw).
- MEM_RD: mem_read=1, i_or_d=1; advance to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; then FETCH.
- MEM_WR:
  - mem_write=1, i_or_d=1; reg_write stays 0 (store never writes the register file).
  - On mem_ready: instr_done=1, go to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=101, pc_source=01.
  - pc_write = condition: beq alu_zero; bne !alu_zero; blt alu_lt; bgt !alu_lt & !alu_zero.
  - instr_done=1; then FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1; then FETCH.
- Wait counter and timeout:
  - The counter increments each cycle in FETCH, MEM_RD or MEM_WR with mem_ready=0, and clears on every state change.
  - When the counter reaches TIMEOUT with mem_ready still 0, the FSM pulses mem_timeout and goes to FETCH with no IR/PC/register/memory update.
  - A timeout in FETCH re-fetches from the same PC.
  - mem_ready=1 on the same cycle as the timeout wins: normal completion, no mem_timeout.
- Latency with mem_ready tied high:
  - R/I-type 4 cycles, lhw 5, shw 4, branch 3, jump 3.
  - instr_done pulses exactly once per instruction, in its final cycle.

Test Plan:
- reset=1 for 2 cycles with opcode=0000 -> state FETCH; outputs all 0 except alu_op=001 and mem_read=1 in the first post-reset cycle.
- mem_ready=1, opcode=0001 -> 4 cycles; ALU_WB shows reg_write=1, reg_dst=0; EXEC_I shows alu_src_b=10, alu_op=001; instr_done on cycle 4.
- opcode=0111 with mem_ready low for 3 cycles in MEM_RD -> mem_read held 4 cycles, then MEM_WB with reg_write=1, mem_to_reg=1.
- opcode=1000 -> MEM_WR mem_write=1, i_or_d=1; reg_write=0 in every cycle of the instruction.
- Branches:
  - beq with alu_zero=1 -> pc_write=1, pc_source=01.
  - bgt with alu_zero=1, alu_lt=0 -> pc_write=0.
  - opcode=0101 -> illegal_op and instr_done pulse in DECODE; the FSM returns to FETCH.
- mem_ready held 0 in FETCH with TIMEOUT=15 -> mem_timeout pulses after 15 waiting cycles; ir_write and pc_write stay 0; FETCH re-entered.
- reset asserted during MEM_WR -> mem_write=0 in the next cycle; state FETCH.
